// File: rtl/ultra_pkg.sv
// -----------------------------------------------------------------------------
// ultra_pkg
// Shared definitions for the ultrasonic ranging path: the capture FSM state
// type, default timing constants and the microsecond-to-centimetre divisor
// that the downstream distance stage also uses.
// -----------------------------------------------------------------------------
package ultra_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE
  } ultra_state_e;

  localparam int unsigned DEF_CLK_HZ     = 100_000_000;
  localparam int unsigned US_DIV         = DEF_CLK_HZ / 1_000_000;
  localparam int unsigned DEF_TIMEOUT_US = 30_000;

  // Round-trip echo time per centimetre of range, in microseconds.
  localparam int unsigned CM_DIV = 58;

  // PCLK cycles per microsecond for a given clock frequency.
  function automatic int unsigned us_div_of(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/echo_sync_filter.sv
// -----------------------------------------------------------------------------
// echo_sync_filter
// Brings the raw asynchronous echo pin into the PCLK domain with a two-flop
// synchronizer, then debounces it: the filtered level only changes after
// FILT_LEN consecutive synchronized samples at the new value. Single-cycle
// rise/fall strobes are issued in the same cycle the filtered level changes.
//
// Ports:
//   PCLK    in   clock
//   PRESET  in   asynchronous active-high reset
//   echo_i  in   raw echo pin (asynchronous)
//   rise_o  out  one-cycle strobe, filtered echo went 0 -> 1
//   fall_o  out  one-cycle strobe, filtered echo went 1 -> 0
// -----------------------------------------------------------------------------
module echo_sync_filter
  import ultra_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  // The run counter holds 0..FILT_LEN-1 samples already seen at the new level.
  localparam int unsigned     CW       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_LEN - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          echo_f_q;
  logic          rise_q;
  logic          fall_q;
  logic [CW-1:0] run_q;

  // NOTE: every flop here uses <= so each stage samples the pre-edge value of
  // the one before it; blocking assignments would collapse the synchronizer.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      echo_f_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      run_q    <= '0;
    end else begin
      sync1_q <= echo_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q == echo_f_q) begin
        // Any sample back at the current level discards a partial run, so
        // pulses shorter than FILT_LEN never reach the filtered output.
        run_q <= '0;
      end else if (run_q == CNT_LAST) begin
        echo_f_q <= sync2_q;
        run_q    <= '0;
        rise_q   <= sync2_q;
        fall_q   <= ~sync2_q;
      end else begin
        run_q <= run_q + CW'(1);
      end
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ultra_echo_capture.sv
// -----------------------------------------------------------------------------
// ultra_echo_capture
// HC-SR04-style ranging front end. On start it drives a TRIG_US trigger
// pulse, waits for a filtered echo rising edge, then measures the echo high
// time in whole microseconds. Both the wait and the measurement are bounded by
// TIMEOUT_US; the result is presented with a one-cycle valid strobe.
//
// Ports:
//   PCLK      in   clock (CLK_HZ, integer multiple of 1 MHz)
//   PRESET    in   asynchronous active-high reset, aborts any measurement
//   start     in   one-cycle measurement request, ignored while busy
//   echo      in   raw sensor echo (asynchronous)
//   trig      out  registered trigger to the sensor
//   busy      out  measurement in progress (through the valid cycle)
//   valid     out  one-cycle result strobe
//   width_us  out  echo high time in microseconds, held until next valid
//   timeout   out  result hit a timeout, held until next valid
// -----------------------------------------------------------------------------
module ultra_echo_capture
  import ultra_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned W          = 15
) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic         start,
  input  logic         echo,
  output logic         trig,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] width_us,
  output logic         timeout
);

  localparam int unsigned   DIV        = us_div_of(CLK_HZ);
  localparam int unsigned   PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [W-1:0]  TRIG_LAST  = W'(TRIG_US - 1);
  localparam logic [W-1:0]  TIMEOUT_W  = W'(TIMEOUT_US);

  ultra_state_e  state_q;
  logic [PW-1:0] presc_q;
  logic [W-1:0]  cnt_q;
  logic [W-1:0]  cnt_d;
  logic          res_to_q;
  logic          trig_q;
  logic          busy_q;
  logic          valid_q;
  logic [W-1:0]  width_q;
  logic          timeout_q;
  logic          us_tick;
  logic          rise;
  logic          fall;

  echo_sync_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .echo_i (echo),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign us_tick = (presc_q == PRESC_LAST);

  // Shared microsecond counter value after this cycle's tick. One counter
  // serves TRIG length, the WAIT_RISE timeout and the echo width, since it is
  // cleared on every state entry.
  // NOTE: cnt_d is given a value on every path through this block, so it
  // synthesizes as pure logic rather than a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (us_tick) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_q     <= '0;
      res_to_q  <= 1'b0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      width_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      presc_q <= us_tick ? '0 : presc_q + PW'(1);
      cnt_q   <= cnt_d;

      case (state_q)
        IDLE: begin
          presc_q <= '0;
          cnt_q   <= '0;
          // busy stays up through the valid cycle, so a start coinciding
          // with valid is dropped and the earliest restart is one cycle later.
          if (valid_q) busy_q <= 1'b0;
          if (start && !busy_q) begin
            state_q <= TRIG;
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        TRIG: begin
          if (us_tick && cnt_q == TRIG_LAST) begin
            state_q <= WAIT_RISE;
            trig_q  <= 1'b0;
            cnt_q   <= '0;
            presc_q <= '0;
          end
        end

        WAIT_RISE: begin
          // Only an edge starts a measurement; an echo already high on entry
          // has to drop and rise again. A rise beats a coincident timeout.
          if (rise) begin
            state_q <= MEASURE;
            cnt_q   <= '0;
            presc_q <= '0;
          end else if (cnt_d == TIMEOUT_W) begin
            state_q  <= DONE;
            cnt_q    <= '0;
            res_to_q <= 1'b1;
            presc_q  <= '0;
          end
        end

        MEASURE: begin
          // cnt_d already includes a tick landing in the fall cycle, so the
          // width is floor(high cycles / DIV). A fall beats saturation.
          if (fall) begin
            state_q  <= DONE;
            res_to_q <= 1'b0;
            presc_q  <= '0;
          end else if (cnt_d == TIMEOUT_W) begin
            state_q  <= DONE;
            res_to_q <= 1'b1;
            presc_q  <= '0;
          end
        end

        DONE: begin
          state_q   <= IDLE;
          width_q   <= cnt_q;
          timeout_q <= res_to_q;
          valid_q   <= 1'b1;
          presc_q   <= '0;
        end

        default: begin
          state_q <= IDLE;
          trig_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trig     = trig_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign width_us = width_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_ultra_echo_capture.sv
// -----------------------------------------------------------------------------
// tb_ultra_echo_capture
// Self-checking bench for ultra_echo_capture at a scaled-down configuration
// (4 MHz PCLK, 3 us trigger, 150 us timeout, 3-sample filter). Expected
// results come from the measurement rule: a raw echo high for N cycles
// yields min(floor(N/div), TIMEOUT_US), with timeout set when N exceeds the
// timeout window; pulses shorter than the filter never start a measurement.
// -----------------------------------------------------------------------------
module tb_ultra_echo_capture;

  localparam int unsigned CLK_HZ     = 4_000_000;
  localparam int unsigned TRIG_US    = 3;
  localparam int unsigned TIMEOUT_US = 150;
  localparam int unsigned FILT_LEN   = 3;
  localparam int unsigned W          = 8;
  localparam int unsigned DIV        = CLK_HZ / 1_000_000;
  localparam int unsigned TMO_CYC    = TIMEOUT_US * DIV;

  typedef struct {
    int unsigned w;
    bit          t;
  } res_t;

  logic         PCLK   = 1'b0;
  logic         PRESET = 1'b1;
  logic         start  = 1'b0;
  logic         echo   = 1'b0;
  logic         trig;
  logic         busy;
  logic         valid;
  logic [W-1:0] width_us;
  logic         timeout;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t vq[$];

  ultra_echo_capture #(
    .CLK_HZ     (CLK_HZ),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TIMEOUT_US),
    .FILT_LEN   (FILT_LEN),
    .W          (W)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .start    (start),
    .echo     (echo),
    .trig     (trig),
    .busy     (busy),
    .valid    (valid),
    .width_us (width_us),
    .timeout  (timeout)
  );

  always #5 PCLK = ~PCLK;

  // Record every result strobe, sampled mid-cycle.
  always @(negedge PCLK) begin : valid_mon
    res_t r;
    if (!PRESET && valid === 1'b1) begin
      r.w = int'(width_us);
      r.t = timeout;
      vq.push_back(r);
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: result for a raw echo pulse of n cycles seen during WAIT_RISE.
  function automatic res_t model(input int unsigned n);
    res_t r;
    if (n < FILT_LEN) begin
      r.w = 0;
      r.t = 1'b1;
    end else if (n > TMO_CYC) begin
      r.w = TIMEOUT_US;
      r.t = 1'b1;
    end else begin
      r.w = n / DIV;
      r.t = 1'b0;
    end
    return r;
  endfunction

  // Pulse start, then measure the trigger length; returns in the first
  // mid-cycle sample where trig is low again.
  task automatic start_and_check_trig(input string tag);
    int unsigned hi;
    @(negedge PCLK);
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    hi = 0;
    while (trig === 1'b1 && hi < 4 * TRIG_US * DIV) begin
      hi++;
      @(negedge PCLK);
    end
    check({tag, "_trig_len"}, hi, TRIG_US * DIV);
  endtask

  task automatic wait_result(input string tag, input int unsigned nprev, input res_t e);
    int unsigned cyc;
    cyc = 0;
    while (vq.size() <= nprev && cyc < 3 * TMO_CYC) begin
      @(negedge PCLK);
      cyc++;
    end
    check({tag, "_valid_seen"}, int'(vq.size() > nprev), 1);
    if (vq.size() > nprev) begin
      check({tag, "_width"}, vq[nprev].w, e.w);
      check({tag, "_timeout"}, int'(vq[nprev].t), int'(e.t));
    end
    repeat (4 * FILT_LEN + 8) @(negedge PCLK);
    check({tag, "_one_valid"}, vq.size(), nprev + 1);
  endtask

  // One measurement: delay after trig falls, optional sub-filter glitches,
  // then a clean echo pulse of n cycles (n = 0: no echo at all).
  task automatic run_meas(input string tag, input int unsigned delay,
                          input int unsigned glitches, input int unsigned n);
    int unsigned nprev;
    nprev = vq.size();
    start_and_check_trig(tag);
    repeat (delay) @(negedge PCLK);
    for (int g = 0; g < int'(glitches); g++) begin
      echo = 1'b1;
      repeat (FILT_LEN - 1) @(negedge PCLK);
      echo = 1'b0;
      repeat (FILT_LEN + 2) @(negedge PCLK);
    end
    if (n > 0) begin
      echo = 1'b1;
      repeat (n) @(negedge PCLK);
      echo = 1'b0;
    end
    wait_result(tag, nprev, model(n));
  endtask

  initial begin : main
    int unsigned nprev;
    int unsigned cyc;
    int unsigned n;
    int unsigned hi;

    // Reset state
    repeat (3) @(negedge PCLK);
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_width", width_us, 0);
    PRESET = 1'b0;
    repeat (3) @(negedge PCLK);

    // No echo: wait-for-rise timeout
    run_meas("noecho", 0, 0, 0);
    // Nominal pulse (58 us)
    run_meas("w58", 200, 0, 58 * DIV);
    // Long echo saturates
    run_meas("sat", 20, 0, TMO_CYC + 200);
    // Saturation boundaries: fall coinciding with saturation wins
    run_meas("edge_eq", 10, 0, TMO_CYC);
    run_meas("edge_p1", 10, 0, TMO_CYC + 1);
    run_meas("edge_m1", 10, 0, TMO_CYC - 1);
    // Filter boundaries: exactly FILT_LEN passes, one less is discarded
    run_meas("filt_eq", 30, 0, FILT_LEN);
    run_meas("filt_m1", 30, 0, FILT_LEN - 1);
    // Glitches in WAIT_RISE, then a clean 11 us pulse
    run_meas("glitch", 20, 3, 11 * DIV);

    // Echo already high on WAIT_RISE entry is not measured
    nprev = vq.size();
    echo = 1'b1;
    repeat (10) @(negedge PCLK);
    start_and_check_trig("stale");
    repeat (40) @(negedge PCLK);
    echo = 1'b0;
    repeat (20) @(negedge PCLK);
    echo = 1'b1;
    repeat (23 * DIV) @(negedge PCLK);
    echo = 1'b0;
    wait_result("stale", nprev, model(23 * DIV));

    // start during MEASURE has no effect
    nprev = vq.size();
    start_and_check_trig("midstart");
    repeat (30) @(negedge PCLK);
    echo = 1'b1;
    repeat (40) @(negedge PCLK);
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    check("midstart_no_trig", trig, 0);
    repeat (59) @(negedge PCLK);
    echo = 1'b0;
    wait_result("midstart", nprev, model(100));

    // busy/valid handshake and back-to-back start
    nprev = vq.size();
    start_and_check_trig("b2b");
    repeat (10) @(negedge PCLK);
    echo = 1'b1;
    repeat (10 * DIV) @(negedge PCLK);
    echo = 1'b0;
    cyc = 0;
    while (valid !== 1'b1 && cyc < 3 * TMO_CYC) begin
      @(negedge PCLK);
      cyc++;
    end
    check("b2b_valid_seen", valid, 1);
    check("b2b_busy_at_valid", busy, 1);
    check("b2b_width", width_us, 10);
    start = 1'b1;                    // sampled with valid high: dropped
    @(negedge PCLK);
    start = 1'b0;
    check("b2b_valid_single", valid, 0);
    check("b2b_busy_after", busy, 0);
    check("b2b_start_ignored", trig, 0);
    start = 1'b1;                    // two cycles after valid: accepted
    @(negedge PCLK);
    start = 1'b0;
    hi = 0;
    while (trig === 1'b1 && hi < 4 * TRIG_US * DIV) begin
      hi++;
      @(negedge PCLK);
    end
    check("b2b2_trig_len", hi, TRIG_US * DIV);
    wait_result("b2b2", nprev + 1, model(0));

    // Reset during TRIG drops trig asynchronously
    @(negedge PCLK);
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rstt_trig_pre", trig, 1);
    #1 PRESET = 1'b1;
    #1;
    check("rstt_trig", trig, 0);
    check("rstt_busy", busy, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (3) @(negedge PCLK);

    // Reset mid-MEASURE aborts with no valid
    nprev = vq.size();
    start_and_check_trig("rstm");
    repeat (10) @(negedge PCLK);
    echo = 1'b1;
    repeat (30) @(negedge PCLK);
    check("rstm_busy_pre", busy, 1);
    #1 PRESET = 1'b1;
    #1;
    check("rstm_busy", busy, 0);
    check("rstm_trig", trig, 0);
    check("rstm_valid", valid, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (20) @(negedge PCLK);
    echo = 1'b0;
    repeat (2 * TMO_CYC) @(negedge PCLK);
    check("rstm_no_valid", vq.size(), nprev);
    run_meas("post_rst", 50, 0, 77);

    // Randomized measurements
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       n = $urandom_range(0, FILT_LEN + 1);
        1:       n = $urandom_range(FILT_LEN, 60);
        2:       n = $urandom_range(60, TMO_CYC);
        default: n = $urandom_range(TMO_CYC - 8, TMO_CYC + 40);
      endcase
      run_meas($sformatf("rand%0d", i), $urandom_range(0, 300), $urandom_range(0, 2), n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ultra_echo_capture.md
# ultra_echo_capture

Front-end for the ultrasonic ranging path. The block drives the HC-SR04-style trigger pulse and brings the asynchronous echo input into the PCLK domain through a synchronizer and glitch filter. It then measures the echo high time in whole microseconds, with a timeout. It sits between the sensor pins and the distance/filter stage, which consumes `width_us` on the `valid` pulse and converts to centimetres (divide by 58).

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, PCLK frequency; must be an integer multiple of 1_000_000.
- `TRIG_US`, 10, trigger pulse length in µs.
- `TIMEOUT_US`, 30_000, limit for both waiting for the echo and the echo high time.
- `FILT_LEN`, 4, consecutive equal samples required before the filtered echo changes.
- `W`, 15, width of `width_us`; must satisfy 2^W > TIMEOUT_US.

Ports:
- `PCLK`  in  1  clock.
- `PRESET`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to begin one measurement.
- `echo`  in  1  raw sensor echo, asynchronous.
- `trig`  out  1  registered trigger to sensor.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle after `valid`.
- `valid`  out  1  single-cycle result strobe.
- `width_us`  out  W  echo high time in µs; held until the next `valid`.
- `timeout`  out  1  qualifies `width_us`; held until the next `valid`.

## Operation
- Reset values: `trig`, `busy`, `valid`, `timeout` = 0; `width_us` = 0; state IDLE; synchronizer and filter outputs = 0.
- Echo path: two-flop synchronizer feeds the filter. `echo_f` takes a new value after `FILT_LEN` consecutive synchronized samples at that value. A pulse shorter than `FILT_LEN` cycles is discarded. `rise` and `fall` are edge strobes on `echo_f`.
- The µs tick prescaler counts 0..CLK_HZ/1e6−1 and pulses `us_tick` at the terminal count. It restarts at 0 on every state entry.
- States:
  - IDLE: `start`=1 → TRIG. `busy` goes high next cycle.
  - TRIG: `trig`=1. After TRIG_US ticks, `trig`=0 → WAIT_RISE.
  - WAIT_RISE: a `rise` is required, so an echo already high on entry is ignored until it falls and rises again. `rise` → MEASURE with the width counter cleared. If TIMEOUT_US ticks elapse first → DONE with width=0, timeout=1.
  - MEASURE: the width counter increments on each `us_tick`. `fall` → DONE with width=counter, timeout=0. If the counter reaches TIMEOUT_US → DONE with width=TIMEOUT_US, timeout=1 (saturating; the counter never wraps).
  - DONE: one cycle. Load `width_us`/`timeout`, assert `valid` → IDLE.
- `start` while `busy` or in DONE is ignored; it is not queued.
- `width_us` = floor(echo_f high cycles / (CLK_HZ/1e6)).
- If `rise` and a timeout occur in the same cycle, `rise` wins. If `fall` and saturation occur in the same cycle, `fall` wins, with width=TIMEOUT_US and timeout=0.
- `PRESET` mid-measurement drops `trig` immediately (asynchronous), aborts the measurement and produces no `valid`.

## Timing
- `start` is sampled at edge N. `trig` is high from N+1 for exactly TRIG_US·CLK_HZ/1e6 cycles (1000 at defaults).
- Echo latency: raw edge to `echo_f` edge is 2 + FILT_LEN cycles, identical for rise and fall, so the latency does not bias the measured width.
- The `fall` detection cycle is DONE−1. `valid` and the new `width_us` appear on the same edge, one cycle after DONE entry.
- `busy` falls the cycle after `valid`. Back-to-back `start` is accepted two cycles after `valid`.
- Worst-case measurement at defaults is about 60 ms: TRIG + WAIT_RISE timeout + MEASURE timeout.

## Structure
- Shared package `ultra_pkg`:
  - `ultra_state_e` (IDLE, TRIG, WAIT_RISE, MEASURE, DONE).
  - Constant `US_DIV = CLK_HZ/1_000_000`.
  - Default `TIMEOUT_US`.
  - The cm conversion constant 58, also used by the downstream stage.
- Sub-module `echo_sync_filter`: synchronizer, FILT_LEN filter and edge strobes. The top level holds the prescaler, the counters and the FSM.

## Test plan
- `start` pulse with echo held low → `trig` high exactly 1000 cycles. After 30_000 µs, `valid`=1, timeout=1, width_us=0.
- Echo rises 200 µs after `trig` falls and stays high 5800 cycles → width_us=58, timeout=0, one `valid`.
- Echo high for 3_100_000 cycles → width_us=30000, timeout=1 at saturation.
- 3-cycle glitches on echo in WAIT_RISE, then a clean 1160-cycle pulse → glitches ignored, width_us=11.
- `start` pulsed during MEASURE → no effect. `PRESET` asserted mid-MEASURE → `trig`/`busy`/`valid` = 0 immediately, no `valid` later. A fresh `start` after reset gives a correct result.
- Echo already high on WAIT_RISE entry for 500 µs, then low, then high for 2320 cycles → width_us=23, the stale high is not measured.
